// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared FSM states, source codes and default timing for the ADC mux scheduler
// contents: state_t (IDLE/SETTLE/REQ/WAIT/GAP), SRC_AA/SRC_LI, DEF_* parameter defaults, ADC_W
package adc_sched_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, GAP} state_t;
  localparam logic SRC_AA = 1'b0;
  localparam logic SRC_LI = 1'b1;
  localparam int DEF_INTERVAL_CYCLES = 41946;
  localparam int DEF_SETTLE_CYCLES = 1000;
  localparam int DEF_AVG_LOG2 = 8;
  localparam int ADC_W = 14;
endpackage

// File: rtl/adc_avg_accum.sv
// adc_avg_accum: boxcar average of 2^AVG_LOG2 samples for one mux source
// ports: clk, reset (sync, active-high), add/data (one sample), val/avg (one-cycle average pulse)
module adc_avg_accum import adc_sched_pkg::*; #(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add,
  input  logic [ADC_W-1:0] data,
  output logic             val,
  output logic [ADC_W-1:0] avg
);
  logic [ADC_W+AVG_LOG2-1:0] sum, tot;
  logic [AVG_LOG2-1:0] cnt;
  assign tot = sum + (ADC_W+AVG_LOG2)'(data);
  always_ff @(posedge clk)
    if (reset) begin
      sum <= '0;
      cnt <= '0;
      val <= 1'b0;
      avg <= '0;
    end else begin
      val <= add && &cnt;
      if (add) begin
        // cnt wraps to zero exactly on the completing sample
        cnt <= cnt + AVG_LOG2'(1);
        sum <= &cnt ? '0 : tot;
        if (&cnt) avg <= tot[ADC_W+AVG_LOG2-1:AVG_LOG2];
      end
    end
endmodule

// File: rtl/adc_mux_scheduler.sv
// adc_mux_scheduler: round-robin ADC mux slot scheduler with settle, request, timeout and per-source averaging
// ports: clk/reset; enable, src_mask, lock_valid/lock_src pick sources; adc_sel/adc_req drive the ADC,
// adc_ready/adc_value return data; sample_*, avg_* and timeout_err report results; busy = not IDLE
module adc_mux_scheduler import adc_sched_pkg::*; #(
  parameter int INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       src_mask,
  input  logic             lock_valid,
  input  logic             lock_src,
  output logic             adc_sel,
  output logic             adc_req,
  input  logic             adc_ready,
  input  logic [ADC_W-1:0] adc_value,
  output logic             sample_val,
  output logic             sample_src,
  output logic [ADC_W-1:0] sample_data,
  output logic             avg_val,
  output logic             avg_src,
  output logic [ADC_W-1:0] avg_data,
  output logic             timeout_err,
  output logic             busy
);
  localparam int CW = $clog2(INTERVAL_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic ptr, nxt, go, last, av_aa, av_li;
  logic [ADC_W-1:0] ad_aa, ad_li;
  assign go = enable && (lock_valid || |src_mask);
  // ptr holds the last served source; try the other one first, fall back to ptr itself
  assign nxt = lock_valid ? lock_src : src_mask[~ptr] ? ~ptr : ptr;
  assign last = cnt == CW'(INTERVAL_CYCLES - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= SRC_LI;
      adc_sel <= SRC_AA;
      adc_req <= 1'b0;
      sample_val <= 1'b0;
      sample_src <= 1'b0;
      sample_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      adc_req <= 1'b0;
      sample_val <= 1'b0;
      timeout_err <= 1'b0;
      cnt <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (go) begin
          state <= SETTLE;
          adc_sel <= nxt;
          ptr <= nxt;
        end
        SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state <= REQ;
          adc_req <= 1'b1;
        end
        REQ: state <= WAIT;
        WAIT: if (adc_ready) begin
          state <= GAP;
          sample_val <= 1'b1;
          sample_data <= adc_value;
          sample_src <= adc_sel;
        end else if (last) begin
          state <= GAP;
          timeout_err <= 1'b1;
        end
        default: ;
      endcase
      // the final slot count closes the slot directly, so back-to-back slots keep requests INTERVAL_CYCLES apart
      if ((state == WAIT || state == GAP) && last) begin
        state <= go ? SETTLE : IDLE;
        if (go) begin
          adc_sel <= nxt;
          ptr <= nxt;
        end
      end
    end
  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_acc_aa (
    .clk(clk),
    .reset(reset),
    .add(sample_val && sample_src == SRC_AA),
    .data(sample_data),
    .val(av_aa),
    .avg(ad_aa)
  );
  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_acc_li (
    .clk(clk),
    .reset(reset),
    .add(sample_val && sample_src == SRC_LI),
    .data(sample_data),
    .val(av_li),
    .avg(ad_li)
  );
  // only one source can complete per cycle since samples arrive one at a time
  assign avg_val = av_aa || av_li;
  assign avg_src = av_li;
  assign avg_data = av_li ? ad_li : ad_aa;
endmodule

// File: tb/tb_adc_mux_scheduler.sv
// tb_adc_mux_scheduler: directed and randomized bench checked against a slot-level reference model
module tb_adc_mux_scheduler;
  localparam int IV = 64;
  localparam int ST = 8;
  localparam int AL = 2;
  logic clk = 0, reset = 1, enable = 0, lock_valid = 0, lock_src = 0, adc_ready = 0;
  logic [1:0] src_mask = '0;
  logic [13:0] adc_value = '0;
  logic adc_sel, adc_req, sample_val, sample_src, avg_val, avg_src, timeout_err, busy;
  logic [13:0] sample_data, avg_data;
  int errors = 0, checks = 0, cyc = 0;
  int exp_req, exp_sv, exp_to, exp_av, slot_start;
  logic exp_sel, exp_busy, sv_src, av_src, ptr, slot_sel, last_avg_src;
  logic [13:0] sv_data, av_data, last_avg;
  int acc_sum [2];
  int acc_n [2];
  int req_prev = 0, req_gap = 0, sv_seen = 0, to_seen = 0, avg_seen = 0;
  int b_sv, b_to, b_av;

  adc_mux_scheduler #(.INTERVAL_CYCLES(IV), .SETTLE_CYCLES(ST), .AVG_LOG2(AL)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .src_mask(src_mask),
    .lock_valid(lock_valid),
    .lock_src(lock_src),
    .adc_sel(adc_sel),
    .adc_req(adc_req),
    .adc_ready(adc_ready),
    .adc_value(adc_value),
    .sample_val(sample_val),
    .sample_src(sample_src),
    .sample_data(sample_data),
    .avg_val(avg_val),
    .avg_src(avg_src),
    .avg_data(avg_data),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  // next source after p, wrapping round the two sources; a locked source overrides
  function automatic logic pick(input logic lv, input logic ls, input logic [1:0] m, input logic p);
    if (lv) return ls;
    for (int i = 1; i <= 2; i++) begin
      int j;
      j = (int'(p) + i) % 2;
      if (m[j]) return j[0];
    end
    return p;
  endfunction

  task automatic model_reset;
    exp_req = -1;
    exp_sv = -1;
    exp_to = -1;
    exp_av = -1;
    exp_sel = 0;
    exp_busy = 0;
    ptr = 1;
    for (int s = 0; s < 2; s++) begin
      acc_sum[s] = 0;
      acc_n[s] = 0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", busy, exp_busy);
    chk("adc_sel", adc_sel, exp_sel);
    chk("adc_req", adc_req, cyc == exp_req);
    chk("sample_val", sample_val, cyc == exp_sv);
    chk("timeout_err", timeout_err, cyc == exp_to);
    chk("avg_val", avg_val, cyc == exp_av);
    if (cyc == exp_sv) begin
      chk("sample_src", sample_src, sv_src);
      chk("sample_data", sample_data, sv_data);
    end
    if (cyc == exp_av) begin
      chk("avg_src", avg_src, av_src);
      chk("avg_data", avg_data, av_data);
    end
    if (adc_req) begin
      req_gap = cyc - req_prev;
      req_prev = cyc;
    end
    if (sample_val) sv_seen++;
    if (timeout_err) to_seen++;
    if (avg_val) begin
      avg_seen++;
      last_avg = avg_data;
      last_avg_src = avg_src;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    model_reset;
    repeat (n) tick;
    chk("rst_sample_data", sample_data, 0);
    chk("rst_sample_src", sample_src, 0);
    chk("rst_avg_data", avg_data, 0);
    chk("rst_avg_src", avg_src, 0);
    reset = 0;
  endtask

  task automatic idle_ticks(input int n);
    exp_busy = 0;
    repeat (n) begin
      tick;
      adc_ready = 1'($urandom);
      adc_value = 14'($urandom);
    end
    adc_ready = 0;
  endtask

  // one full slot; the next clock edge must be a slot start. rc = slot count at which ready is
  // presented, ck = count at which mask/enable change, rk = count at which reset is asserted
  task automatic run_slot(input int rc, input logic [13:0] v, input int ck, input logic [1:0] cm,
                          input logic ce, input int rk);
    logic s;
    s = pick(lock_valid, lock_src, src_mask, ptr);
    ptr = s;
    exp_sel = s;
    exp_busy = 1;
    slot_start = cyc + 1;
    exp_req = slot_start + ST;
    for (int k = 0; k < IV; k++) begin
      tick;
      if (k == 0) slot_sel = adc_sel;
      adc_ready = (k == rc);
      adc_value = (k == rc) ? v : 14'($urandom);
      if (k == ck) begin
        src_mask = cm;
        enable = ce;
      end
      if (k == rk) begin
        reset = 1;
        model_reset;
        tick;
        reset = 0;
        adc_ready = 0;
        return;
      end
      if (k == rc && k > ST) begin
        exp_sv = cyc + 1;
        sv_src = s;
        sv_data = v;
        acc_sum[s] += int'(v);
        acc_n[s]++;
        if (acc_n[s] == (1 << AL)) begin
          exp_av = cyc + 2;
          av_src = s;
          av_data = 14'(acc_sum[s] >> AL);
          acc_sum[s] = 0;
          acc_n[s] = 0;
        end
      end
    end
    if (!(rc > ST && rc < IV)) exp_to = slot_start + IV;
  endtask

  initial begin
    model_reset;
    enable = 1;
    src_mask = 2'b11;
    do_reset(3);

    // alternating round-robin, ready 3 cycles after each request
    run_slot(ST + 3, 14'($urandom), -1, 2'b11, 1, -1);
    chk("rr_sel0", slot_sel, 0);
    chk("req_at_8", req_prev - slot_start, ST);
    run_slot(ST + 3, 14'($urandom), -1, 2'b11, 1, -1);
    chk("rr_sel1", slot_sel, 1);
    chk("req_gap1", req_gap, IV);
    run_slot(ST + 3, 14'($urandom), -1, 2'b11, 1, -1);
    chk("rr_sel2", slot_sel, 0);
    chk("req_gap2", req_gap, IV);

    // locked source, averaging 100..103
    do_reset(2);
    lock_valid = 1;
    lock_src = 1;
    b_av = avg_seen;
    for (int i = 0; i < 4; i++) run_slot(20, 14'(100 + i), -1, 2'b11, 1, -1);
    chk("avg_count", avg_seen - b_av, 1);
    chk("avg_value", last_avg, 101);
    chk("avg_src_li", last_avg_src, 1);

    // missing conversions, then ready exactly on the timeout count
    lock_valid = 0;
    b_sv = sv_seen;
    b_to = to_seen;
    b_av = avg_seen;
    run_slot(-1, 14'($urandom), -1, 2'b11, 1, -1);
    run_slot(-1, 14'($urandom), -1, 2'b11, 1, -1);
    run_slot(IV - 1, 14'($urandom), -1, 2'b11, 1, -1);
    run_slot(30, 14'($urandom), -1, 2'b11, 1, -1);
    chk("timeouts", to_seen - b_to, 2);
    chk("samples", sv_seen - b_sv, 2);
    chk("no_avg", avg_seen - b_av, 0);

    // mask narrowed mid-slot applies from the next slot
    run_slot(15, 14'($urandom), 20, 2'b01, 1, -1);
    run_slot(15, 14'($urandom), -1, 2'b01, 1, -1);
    chk("mask_sel_a", slot_sel, 0);
    run_slot(15, 14'($urandom), -1, 2'b01, 1, -1);
    chk("mask_sel_b", slot_sel, 0);

    // reset in WAIT with three samples pending, coinciding with ready
    do_reset(2);
    lock_valid = 1;
    lock_src = 1;
    for (int i = 0; i < 3; i++) run_slot(20, 14'($urandom), -1, 2'b11, 1, -1);
    run_slot(30, 14'($urandom), -1, 2'b11, 1, 30);
    chk("rst_busy", busy, 0);
    b_av = avg_seen;
    for (int i = 0; i < 3; i++) run_slot(20, 14'($urandom), -1, 2'b11, 1, -1);
    chk("rst_avg_none", avg_seen - b_av, 0);
    run_slot(20, 14'($urandom), -1, 2'b11, 1, -1);
    chk("rst_avg_one", avg_seen - b_av, 1);

    // enable falls mid-slot: slot completes, accumulators retained
    lock_valid = 0;
    run_slot(25, 14'($urandom), 30, 2'b11, 0, -1);
    idle_ticks(10);
    enable = 1;
    src_mask = 2'b00;
    idle_ticks(10);
    src_mask = 2'b11;

    // randomized slots
    for (int n = 0; n < 40; n++) begin
      logic ce;
      lock_valid = ($urandom_range(0, 3) == 0);
      lock_src = 1'($urandom);
      src_mask = 2'($urandom_range(1, 3));
      ce = ($urandom_range(0, 7) != 0);
      run_slot($urandom_range(5, 70), 14'($urandom), $urandom_range(0, IV - 1),
               2'($urandom_range(1, 3)), ce, -1);
      if (!ce) begin
        idle_ticks($urandom_range(1, 6));
        enable = 1;
      end
    end
    enable = 0;
    idle_ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
